// File: rtl/fc_out_pkg.sv
// fc_out_pkg: shared definitions for the fully-connected output layer.
//   state_t          : FSM state encoding used by fc_out
//   FRAC_DEF         : default number of fractional bits per word
//   W_DEF            : default word width
//   SAT_MAX/SAT_MIN  : saturation limits for the default word width
package fc_out_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FRAC_DEF = 24;
    localparam int W_DEF    = 32;

    localparam logic [W_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [W_DEF-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/fc_out_mac_sat.sv
// mac_sat: one multiply-accumulate per enabled cycle, plus saturation of the
// accumulator back to a WIDTH-bit word.
//   clk, rst : clock, async active-high reset
//   en       : perform a MAC this cycle
//   first    : preload the sign-extended bias instead of the running sum
//   w, h, b  : weight, hidden element, bias (signed fixed point)
//   y_sat    : current accumulator saturated to WIDTH bits
module mac_sat #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             first,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] h,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_sat
);

    localparam int ACCW = WIDTH + 8;

    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    term;
    logic signed [ACCW-1:0]    base;
    logic signed [ACCW-1:0]    acc_q;
    logic signed [ACCW-1:0]    acc_d;
    logic                      in_range;

    assign prod  = $signed(w) * $signed(h);
    assign term  = ACCW'(prod >>> FRAC);
    assign base  = first ? {{8{b[WIDTH-1]}}, b} : acc_q;
    assign acc_d = base + term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_d_reg_update: acc_q <= acc_d;
        end
    end

    // The value fits in WIDTH bits when every bit above the WIDTH-1 sign
    // position matches that sign bit.
    assign in_range = (acc_q[ACCW-1:WIDTH-1] == '0) || (acc_q[ACCW-1:WIDTH-1] == '1);

    always_comb begin
        y_sat = acc_q[WIDTH-1:0];
        if (!in_range) begin
            y_sat = acc_q[ACCW-1] ? SAT_LO : SAT_HI;
        end
    end

endmodule

// File: rtl/fc_out.sv
// fc_out: fully-connected output layer with argmax classification.
// Accepts a hidden-state vector, computes y_j = sat(b_j + sum_k (w(j,k)*h(k)) >>> FRAC)
// with one MAC per cycle, and presents y plus the argmax index.
//   clk, rst         : clock, async active-high reset
//   i_h, i_valid     : hidden-state vector and its valid; o_ready = accepting
//   i_w, i_b         : quasi-static weights and biases
//   o_y, o_class     : output vector and argmax index (lowest index on ties)
//   o_valid, i_ready : output handshake
//
// state | meaning
// IDLE  | waiting for i_valid, o_ready=1
// MAC   | one MAC per cycle over (j,k); final cycle drains the last y write
// DONE  | o_y/o_class valid, held until i_ready
module fc_out
    import fc_out_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_LSTM = 8,
    parameter int NUM_OUT  = 4,
    parameter int FRAC     = FRAC_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_LSTM*WIDTH-1:0]         i_h,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [NUM_OUT*NUM_LSTM*WIDTH-1:0] i_w,
    input  logic [NUM_OUT*WIDTH-1:0]          i_b,
    output logic [NUM_OUT*WIDTH-1:0]          o_y,
    output logic [$clog2(NUM_OUT)-1:0]        o_class,
    output logic                              o_valid,
    input  logic                              i_ready
);

    localparam int JW = $clog2(NUM_OUT + 1);
    localparam int CW = $clog2(NUM_OUT);
    localparam int KW = $clog2(NUM_LSTM);

    state_t state_q, state_d;

    logic [NUM_LSTM*WIDTH-1:0] h_buf;
    logic [JW-1:0]             j;
    logic [KW-1:0]             k;
    logic [CW-1:0]             j_idx;
    logic                      drain;
    logic                      k_last;
    logic                      mac_en;
    logic [WIDTH-1:0]          w_sel, h_sel, b_sel, y_sat;
    logic                      wr_pend;
    logic [CW-1:0]             wr_idx;
    logic [NUM_OUT*WIDTH-1:0]  y_q;
    logic [WIDTH-1:0]          best;
    logic [CW-1:0]             cls;

    assign j_idx  = j[CW-1:0];
    // j reaches NUM_OUT for one cycle after the last MAC so the final
    // saturated write (one cycle behind the accumulator) can land.
    assign drain  = (j == JW'(NUM_OUT));
    assign k_last = (k == KW'(NUM_LSTM - 1));
    assign mac_en = (state_q == MAC) && !drain;

    assign w_sel = i_w[(int'(j_idx) * NUM_LSTM + int'(k)) * WIDTH +: WIDTH];
    assign h_sel = h_buf[int'(k) * WIDTH +: WIDTH];
    assign b_sel = i_b[int'(j_idx) * WIDTH +: WIDTH];

    mac_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mac_sat (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .first (k == '0),
        .w     (w_sel),
        .h     (h_sel),
        .b     (b_sel),
        .y_sat (y_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = MAC;
            MAC:     if (drain)   state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_buf   <= '0;
            j       <= '0;
            k       <= '0;
            wr_pend <= 1'b0;
            wr_idx  <= '0;
            y_q     <= '0;
            best    <= '0;
            cls     <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (state_q == IDLE && i_valid) begin
                h_buf <= i_h;
                j     <= '0;
                k     <= '0;
            end
            if (mac_en) begin
                if (k_last) begin
                    k       <= '0;
                    j       <= j + 1'b1;
                    wr_pend <= 1'b1;
                    wr_idx  <= j_idx;
                end else begin
                    k <= k + 1'b1;
                end
            end
            if (wr_pend) begin
                y_q[int'(wr_idx) * WIDTH +: WIDTH] <= y_sat;
                // Strict compare keeps the earlier (lower) index on ties.
                if (wr_idx == '0 || $signed(y_sat) > $signed(best)) begin
                    best <= y_sat;
                    cls  <= wr_idx;
                end
            end
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_y     = y_q;
    assign o_class = cls;

endmodule

// File: tb/tb_fc_out.sv
module tb_fc_out;

    localparam int W  = 32;
    localparam int NL = 8;
    localparam int NO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NL*W-1:0]    i_h;
    logic               i_valid;
    logic               o_ready;
    logic [NO*NL*W-1:0] i_w;
    logic [NO*W-1:0]    i_b;
    logic [NO*W-1:0]    o_y;
    logic [1:0]         o_class;
    logic               o_valid;
    logic               i_ready;

    typedef struct packed {
        logic [NO*W-1:0] y;
        logic [1:0]      cls;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    fc_out dut (
        .clk     (clk),
        .rst     (rst),
        .i_h     (i_h),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_w     (i_w),
        .i_b     (i_b),
        .o_y     (o_y),
        .o_class (o_class),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    // Reference model: wide integer arithmetic, saturate at the end.
    task automatic model(input logic [NL*W-1:0] hv, output exp_t e);
        longint acc, p;
        logic [W-1:0] yj, bst;
        e = '0;
        bst = '0;
        for (int j = 0; j < NO; j++) begin
            acc = longint'($signed(i_b[j*W +: W]));
            for (int k = 0; k < NL; k++) begin
                p = longint'($signed(i_w[(j*NL+k)*W +: W])) * longint'($signed(hv[k*W +: W]));
                acc = acc + (p >>> 24);
            end
            if (acc > 64'sh7FFF_FFFF)        yj = 32'h7FFF_FFFF;
            else if (acc < -64'sh8000_0000)  yj = 32'h8000_0000;
            else                             yj = acc[W-1:0];
            e.y[j*W +: W] = yj;
            if (j == 0 || $signed(yj) > $signed(bst)) begin
                bst = yj;
                e.cls = 2'(j);
            end
        end
    endtask

    task automatic start_inf(input logic [NL*W-1:0] hv);
        exp_t e;
        model(hv, e);
        sb.push_back(e);
        i_h = hv;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_h = ~hv;  // must not affect the running inference
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (o_valid) return;
        end
        cyc = -1;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic set_nominal(output logic [NL*W-1:0] hv);
        for (int k = 0; k < NL; k++) hv[k*W +: W] = 32'h0100_0000;
        for (int n = 0; n < NO*NL; n++) i_w[n*W +: W] = 32'h0080_0000;
        i_b = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_y !== '0) begin errors++; $display("FAIL reset_y: got %h want 0", o_y); end
        checks++; if (o_class !== 2'd0) begin errors++; $display("FAIL reset_class: got %0d want 0", o_class); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_nominal();
        logic [NL*W-1:0] hv;
        exp_t e;
        int cyc;
        set_nominal(hv);
        start_inf(hv);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL nom_busy: o_ready got %b want 0", o_ready); end
        wait_valid(cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL nom_latency: got %0d want 33", cyc); end
        e = sb.pop_front();
        checks++; if (o_y !== e.y) begin errors++; $display("FAIL nom_y_model: got %h want %h", o_y, e.y); end
        checks++; if (o_y !== {4{32'h0400_0000}}) begin errors++; $display("FAIL nom_y: got %h want 4x04000000", o_y); end
        checks++; if (o_class !== 2'd0) begin errors++; $display("FAIL nom_class: got %0d want 0", o_class); end
        consume();
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL nom_release: ready=%b valid=%b want 1/0", o_ready, o_valid); end
    endtask

    task automatic test_saturation();
        logic [NL*W-1:0] hv;
        exp_t e;
        int cyc;
        for (int k = 0; k < NL; k++) hv[k*W +: W] = 32'h6400_0000;
        i_w = '0;
        i_w[(0*NL+0)*W +: W] = 32'h6400_0000;
        i_w[(1*NL+0)*W +: W] = 32'h9C00_0000;
        i_b = '0;
        start_inf(hv);
        wait_valid(cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL sat_latency: got %0d want 33", cyc); end
        e = sb.pop_front();
        checks++; if (o_y[0 +: W] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_y0: got %h want 7fffffff", o_y[0 +: W]); end
        checks++; if (o_y[W +: W] !== 32'h8000_0000) begin errors++; $display("FAIL sat_y1: got %h want 80000000", o_y[W +: W]); end
        checks++; if (o_y !== e.y) begin errors++; $display("FAIL sat_y_model: got %h want %h", o_y, e.y); end
        checks++; if (o_class !== e.cls) begin errors++; $display("FAIL sat_class: got %0d want %0d", o_class, e.cls); end
        consume();
    endtask

    task automatic test_bias_argmax();
        logic [NL*W-1:0] hv;
        exp_t e;
        int cyc;
        set_nominal(hv);
        i_w = '0;
        i_b = {32'hFF00_0000, 32'h0300_0000, 32'h0300_0000, 32'h0100_0000};
        start_inf(hv);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++; if (o_y !== i_b) begin errors++; $display("FAIL bias_y: got %h want %h", o_y, i_b); end
        checks++; if (o_y !== e.y) begin errors++; $display("FAIL bias_y_model: got %h want %h", o_y, e.y); end
        checks++; if (o_class !== 2'd1) begin errors++; $display("FAIL bias_class_tie: got %0d want 1", o_class); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [NL*W-1:0] hv;
        exp_t e;
        int cyc;
        set_nominal(hv);
        i_b = {32'h0, 32'h0, 32'h0200_0000, 32'h0};
        start_inf(hv);
        wait_valid(cyc);
        e = sb.pop_front();
        for (int c = 0; c < 10; c++) begin
            i_valid = c[0];
            i_h = {NL{32'h0700_0000}};
            @(posedge clk);
            #1;
            checks++; if (o_y !== e.y || o_class !== e.cls) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%0d want %h/%0d", c, o_y, o_class, e.y, e.cls); end
            checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL bp_state[%0d]: ready=%b valid=%b want 0/1", c, o_ready, o_valid); end
        end
        i_valid = 1'b0;
        consume();
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", o_ready, o_valid); end
        @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: ready=%b want 1", o_ready); end
    endtask

    task automatic test_reset_mid_mac();
        logic [NL*W-1:0] hv;
        exp_t e;
        int cyc;
        set_nominal(hv);
        start_inf(hv);
        void'(sb.pop_front());  // inference is aborted; drop its expectation
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_hs: valid=%b ready=%b want 0/1", o_valid, o_ready); end
        checks++; if (o_y !== '0 || o_class !== 2'd0) begin errors++; $display("FAIL mid_rst_y: got %h/%0d want 0/0", o_y, o_class); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_inf(hv);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++; if (cyc != 33) begin errors++; $display("FAIL mid_rst_latency: got %0d want 33", cyc); end
        checks++; if (o_y !== {4{32'h0400_0000}} || o_y !== e.y) begin errors++; $display("FAIL mid_rst_rerun_y: got %h want 4x04000000", o_y); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [NL*W-1:0] hv;
        exp_t e;
        int cyc;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NL; k++) hv[k*W +: W] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
            for (int n = 0; n < NO*NL; n++) i_w[n*W +: W] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
            for (int j = 0; j < NO; j++) i_b[j*W +: W] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
            start_inf(hv);
            wait_valid(cyc);
            e = sb.pop_front();
            checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 33", t, cyc); end
            checks++; if (o_y !== e.y) begin errors++; $display("FAIL b2b_y[%0d]: got %h want %h", t, o_y, e.y); end
            checks++; if (o_class !== e.cls) begin errors++; $display("FAIL b2b_class[%0d]: got %0d want %0d", t, o_class, e.cls); end
            consume();
        end
    endtask

    initial begin
        rst = 1'b1;
        i_h = '0;
        i_valid = 1'b0;
        i_w = '0;
        i_b = '0;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_nominal();
        test_saturation();
        test_bias_argmax();
        test_backpressure();
        test_reset_mid_mac();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_out.md
FC_OUT -- requirements
Module: fc_out

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, meaning the signed fixed-point word width.
REQ-002 The block SHALL provide parameter NUM_LSTM, default 8, meaning the number of hidden-state elements consumed.
REQ-003 The block SHALL provide parameter NUM_OUT, default 4, meaning the number of output neurons.
REQ-004 The block SHALL provide parameter FRAC, default 24, meaning the number of fractional bits in every word.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_h, input, NUM_LSTM*WIDTH bits: the signed hidden-state vector from the LSTM array; element k sits at bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port i_valid, input, 1 bit: i_h is valid this cycle.
REQ-009 The block SHALL have port o_ready, output, 1 bit: the block can accept i_h.
REQ-010 The block SHALL have port i_w, input, NUM_OUT*NUM_LSTM*WIDTH bits: static weights; weight (j,k) sits at bits [(j*NUM_LSTM+k)*WIDTH +: WIDTH].
REQ-011 The block SHALL have port i_b, input, NUM_OUT*WIDTH bits: static biases; bias j sits at bits [j*WIDTH +: WIDTH].
REQ-012 The block SHALL have port o_y, output, NUM_OUT*WIDTH bits: the signed output vector, y_j at bits [j*WIDTH +: WIDTH].
REQ-013 The block SHALL have port o_class, output, clog2(NUM_OUT) bits: the argmax index of o_y.
REQ-014 The block SHALL have port o_valid, output, 1 bit: o_y and o_class are valid.
REQ-015 The block SHALL have port i_ready, input, 1 bit: the consumer accepts o_y.

Function
REQ-016 The FSM SHALL have three states: IDLE, MAC and DONE; o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, when i_valid=1, the block SHALL register i_h into an internal buffer and enter MAC with j=0 and k=0.
REQ-018 In MAC, the block SHALL perform exactly one multiply-accumulate per cycle, acc += (w(j,k)*h(k)) >>> FRAC (arithmetic shift), using a full 2*WIDTH-bit product.
REQ-019 The accumulator SHALL be WIDTH+8 bits wide, and it SHALL be preloaded with sign-extended b_j at k=0 of each neuron.
REQ-020 At k=NUM_LSTM-1, the block SHALL write y_j saturated to WIDTH bits (max 0x7FFF_FFFF, min 0x8000_0000 for WIDTH=32), set k to 0, and advance j.
REQ-021 After y_(NUM_OUT-1) is written, the FSM SHALL enter DONE.
REQ-022 o_valid SHALL rise exactly NUM_OUT*NUM_LSTM+1 cycles after the accept edge (33 for the defaults).
REQ-023 The running argmax SHALL be updated as each y_j is written; ties SHALL resolve to the lowest index, so o_class is final when o_valid rises.
REQ-024 In DONE, o_y and o_class SHALL hold stable while i_ready=0; when i_ready=1 the FSM SHALL return to IDLE on the next edge.
REQ-025 i_valid SHALL be ignored outside IDLE, and changes to i_h after the accept edge SHALL have no effect.
REQ-026 i_w and i_b SHALL be treated as quasi-static; changing them while in MAC gives an undefined result for that inference only.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, o_ready=1, o_valid=0, o_y=0, o_class=0, and the accumulator, counters and buffer SHALL be 0.
REQ-028 Reset asserted in MAC or DONE SHALL abort the inference immediately with no partial result retained.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, FRAC, and the saturation limit constants.
REQ-030 A single sub-module, mac_sat, SHALL implement the multiply, shift, accumulate and saturate datapath; fc_out SHALL hold the FSM, counters, buffer and argmax logic.

Verification
REQ-031 Nominal: h=1.0 (0x0100_0000) for all k, w=0.5 (0x0080_0000) for all (j,k), b=0 -> every y_j=0x0400_0000, o_class=0, o_valid rises 33 cycles after accept.
REQ-032 Saturation: h=100.0, w0=+100.0, w1=-100.0 -> y_0=0x7FFF_FFFF and y_1=0x8000_0000.
REQ-033 Bias/argmax: w=0, b={0x0100_0000, 0x0300_0000, 0x0300_0000, -0x0100_0000} -> o_y equals b and o_class=1 (lowest index wins the tie).
REQ-034 Backpressure: hold i_ready=0 for 10 cycles in DONE while pulsing i_valid -> o_y stable, o_ready=0, no new accept; raising i_ready gives IDLE one cycle later.
REQ-035 Reset mid-MAC: assert rst 10 cycles after accept -> o_valid=0, o_y=0, o_ready=1 immediately; a new inference after reset matches the REQ-031 result.
